store_coalesce_buffer: RTL
==========================

Name: store_coalesce_buffer

Overview:
- Parametrised successor to the combinational store-merge logic in the dcache write path.
- Holds up to DEPTH line-sized entries, each with data and a per-byte valid mask.
- Merges st.b/st.h/st.w stores into these entries and coalesces stores to the same line.
- Drains entries oldest-first to the memory side over a valid/ready port. Sits between the dcache store stage and the AXI write arbiter.

Parameters:
- ADDR_W, 32, address width.
- LINE_BYTES, 16, bytes per line; power of two, at least 4.
- DEPTH, 4, number of entries; power of two, at least 2.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- st_valid  in  1  store request.
- st_ready  out  1  store accepted when st_valid and st_ready are both high.
- st_addr  in  ADDR_W  byte address.
- st_data  in  32  store data, right-aligned.
- st_type  in  3  mem_type encoding: 001 st.w, 110 st.b, 111 st.h; all other codes are non-stores.
- misalign  out  1  one-cycle pulse the cycle after a misaligned store is accepted.
- dr_valid  out  1  head entry valid.
- dr_ready  in  1  memory side accepts the head.
- dr_addr  out  ADDR_W  line address of the head; low log2(LINE_BYTES) bits are zero.
- dr_data  out  8*LINE_BYTES  head line data.
- dr_mask  out  LINE_BYTES  head byte-valid mask.
- empty  out  1  no valid entries; used by fence/ibar.

Behaviour:
- Reset (asynchronous, any cycle, including mid-drain): all entries invalid, head=tail=count=0, dr_valid=0, misalign=0, empty=1. Outputs registered or derived from registered state only.
- Byte lane: off = st_addr[log2(LINE_BYTES)-1:0].
  - st.b sets mask bit off.
  - st.h sets bits off..off+1.
  - st.w sets bits off..off+3.
  - Data bytes go into the same lanes. Lanes outside the mask are left unchanged.
- Misaligned store (st.h with addr[0]=1, or st.w with addr[1:0]≠0): accepted, entry state unchanged, misalign=1 in the next cycle.
- Non-store st_type: accepted, no effect.
- Tag = st_addr[ADDR_W-1:log2(LINE_BYTES)].
- Coalesce hit: a valid entry other than the current head has a matching tag. At most one such entry can exist.
  - On a hit, merge into that entry in the next cycle. count is unchanged.
- Miss: allocate the tail entry. Its mask becomes the store's lane mask; tail and count increment.
- The head is never merged into, because it may be mid-handshake. A store to the head's line always allocates a new entry.
- st_ready = (count < DEPTH) or coalesce hit. It does not depend on dr_ready, so there is no combinational path from dr_ready to st_ready.
- Full: count=DEPTH and no hit gives st_ready=0. A store stalls until a drain frees space, and is accepted one cycle after the drain handshake.
- Drain: dr_valid = (count ≠ 0). Fields always reflect the head.
  - On dr_valid and dr_ready, the head is invalidated, head increments (wraps modulo DEPTH) and count decrements.
  - dr_* fields stay stable while dr_valid=1 and dr_ready=0.
- Same cycle accept and drain:
  - Allocate + drain: count unchanged.
  - Coalesce into entry k + drain of head: both apply.
  - A store to the line just drained, in the same cycle, allocates; it does not hit.
- Ordering: entries drain in allocation order. A coalesced store keeps the entry's original position.
- empty = (count == 0).
- Latency: an accepted store can appear on dr_* no earlier than the next cycle.

Optional Feature:
- Macro SCB_LOAD_FWD_EN adds inputs ld_addr[ADDR_W] and outputs ld_fwd_data[8*LINE_BYTES] and ld_fwd_mask[LINE_BYTES]. These are combinational from ld_addr and state.
  - For each byte lane, the value comes from the youngest valid entry with a matching tag whose mask bit is set.
  - Mask bits are the OR across all matching entries.
- Without the macro, these ports and logic are absent. The dcache must then wait for empty before a load miss to a buffered line.

Decomposition:
- Shared package mem_pkg:
  - mem_type constants MT_STW=3'b001, MT_STB=3'b110, MT_STH=3'b111.
  - A function giving store size from mem_type.
  - A line typedef parametrised by LINE_BYTES.
- Sub-module scb_lane_merge: combinational; takes off, st_type and st_data; produces the LINE_BYTES byte-enable, the data replicated onto lanes, and the misaligned flag. Instantiated once.

Test Plan:
- Reset then st.w addr=0x1004 data=0xDEADBEEF, hold dr_ready=0 → next cycle dr_valid=1, dr_addr=0x1000, dr_mask=0x00F0, dr_data[63:32]=0xDEADBEEF, empty=0.
- Stores to 0x2000 (st.w) and 0x3000, then st.b 0x3005 data=0xAA and st.h 0x300E data=0x1234 with dr_ready=0 → the 0x3000 entry has mask=0xC02F, byte5=0xAA, bytes14..15=0x1234; count=2.
- DEPTH=4: fill four distinct lines with dr_ready=0 → st_ready=0 for a fifth distinct line. A store to line 2 still has st_ready=1. Pulse dr_ready → the fifth store is accepted the following cycle; drain order is the four lines in order, then the fifth.
- st.h at 0x1001 → accepted, misalign=1 for exactly one cycle, buffer unchanged.
- One entry at 0x4000 being drained (dr_ready=1) while st.b to 0x4003 arrives → a new entry is allocated; after the drain dr_addr=0x4000, dr_mask=0x0008.
- Assert rst while count=3 and dr_valid=1 → dr_valid=0 and empty=1 immediately; the first store after release drains alone.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared memory-op definitions for the dcache store path.
// Contents: mem_type store encodings, store size decode, byte and default line types.
package mem_pkg;

    localparam logic [2:0] MT_STW = 3'b001;
    localparam logic [2:0] MT_STB = 3'b110;
    localparam logic [2:0] MT_STH = 3'b111;

    localparam int unsigned LINE_BYTES_DFLT = 16;

    typedef logic [7:0] byte_t;

    // Packages cannot take parameters; modules build their own line type as
    // byte_t [LINE_BYTES-1:0]. This is the default-sized version.
    typedef byte_t [LINE_BYTES_DFLT-1:0] line_t;

    // Store size in bytes for a mem_type code; 0 for non-stores.
    function automatic logic [2:0] store_size(input logic [2:0] mt);
        case (mt)
            MT_STW:  return 3'd4;
            MT_STH:  return 3'd2;
            MT_STB:  return 3'd1;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/scb_lane_merge.sv
// Lane steering for one store into a cache line (combinational).
// Ports:
//   off          byte offset of the store within the line
//   st_type      mem_type code
//   st_data      right-aligned store data
//   be_c         per-lane byte enable (all zero for non-stores and misaligned stores)
//   lane_data_c  store data replicated so each enabled lane holds its byte
//   misalign_c   store is an st.h/st.w not aligned to its size
module scb_lane_merge
    import mem_pkg::*;
#(
    parameter int unsigned LINE_BYTES = 16
)(
    input  logic [$clog2(LINE_BYTES)-1:0] off,
    input  logic [2:0]                    st_type,
    input  logic [31:0]                   st_data,
    output logic [LINE_BYTES-1:0]         be_c,
    output logic [8*LINE_BYTES-1:0]       lane_data_c,
    output logic                          misalign_c
);

    logic [2:0]  size;
    logic [31:0] word;
    int unsigned off_i;
    int unsigned size_i;

    // Aligned stores land on lanes whose index mod size matches the data byte,
    // so replicating the data word across the line puts every byte in place.
    always_comb begin
        size        = store_size(st_type);
        misalign_c  = 1'b0;
        word        = st_data;
        be_c        = '0;
        lane_data_c = '0;
        off_i       = 32'(off);
        size_i      = 32'(size);
        case (size)
            3'd1:    word = {4{st_data[7:0]}};
            3'd2: begin
                word       = {2{st_data[15:0]}};
                misalign_c = off[0];
            end
            3'd4:    misalign_c = |off[1:0];
            default: word = st_data;
        endcase
        for (int unsigned k = 0; k < LINE_BYTES; k++) begin
            lane_data_c[8*k +: 8] = word[8*(k % 4) +: 8];
            be_c[k] = (size_i != 0) && !misalign_c && (k >= off_i) && (k < off_i + size_i);
        end
    end

endmodule

// File: rtl/store_coalesce_buffer.sv
// Store coalescing buffer between the dcache store stage and the AXI write arbiter.
// Holds DEPTH line entries (data + byte mask), merges stores into non-head entries of
// the same line, and drains entries oldest-first over a valid/ready port.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   st_valid/st_ready     store handshake; st_addr/st_data/st_type store payload
//   misalign              one-cycle pulse after a misaligned store is accepted
//   dr_valid/dr_ready     drain handshake; dr_addr/dr_data/dr_mask head entry
//   empty                 no valid entries
// Optional (macro SCB_LOAD_FWD_EN): ld_addr in, ld_fwd_data/ld_fwd_mask out,
//   combinational byte forwarding from buffered lines to a load.
module store_coalesce_buffer
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned LINE_BYTES = 16,
    parameter int unsigned DEPTH      = 4
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    st_valid,
    output logic                    st_ready,
    input  logic [ADDR_W-1:0]       st_addr,
    input  logic [31:0]             st_data,
    input  logic [2:0]              st_type,
    output logic                    misalign,
    output logic                    dr_valid,
    input  logic                    dr_ready,
    output logic [ADDR_W-1:0]       dr_addr,
    output logic [8*LINE_BYTES-1:0] dr_data,
    output logic [LINE_BYTES-1:0]   dr_mask,
`ifdef SCB_LOAD_FWD_EN
    input  logic [ADDR_W-1:0]       ld_addr,
    output logic [8*LINE_BYTES-1:0] ld_fwd_data,
    output logic [LINE_BYTES-1:0]   ld_fwd_mask,
`endif
    output logic                    empty
);

    localparam int unsigned OFF_W = $clog2(LINE_BYTES);
    localparam int unsigned TAG_W = ADDR_W - OFF_W;
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = IDX_W + 1;

    typedef byte_t [LINE_BYTES-1:0] scb_line_t;

    // Entry storage
    logic [DEPTH-1:0]      ent_vld;
    logic [TAG_W-1:0]      ent_tag  [DEPTH];
    scb_line_t             ent_data [DEPTH];
    logic [LINE_BYTES-1:0] ent_mask [DEPTH];

    logic [IDX_W-1:0] head;
    logic [IDX_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic [TAG_W-1:0]         st_tag;
    logic [LINE_BYTES-1:0]    be_c;
    logic [8*LINE_BYTES-1:0]  lane_data_c;
    logic                     misalign_c;
    logic                     hit_c;
    logic [IDX_W-1:0]         hit_idx_c;
    logic                     accept_c;
    logic                     wr_en_c;
    logic                     alloc_c;
    logic                     drain_c;
    logic [IDX_W-1:0]         wr_idx_c;
    scb_line_t                wr_line_c;
    logic [CNT_W-1:0]         count_nxt_c;

    assign st_tag = st_addr[ADDR_W-1:OFF_W];

    scb_lane_merge #(
        .LINE_BYTES (LINE_BYTES)
    ) u_lane_merge (
        .off         (st_addr[OFF_W-1:0]),
        .st_type     (st_type),
        .st_data     (st_data),
        .be_c        (be_c),
        .lane_data_c (lane_data_c),
        .misalign_c  (misalign_c)
    );

    // Coalesce lookup; the head is excluded because it may be mid-handshake.
    always_comb begin
        hit_c     = 1'b0;
        hit_idx_c = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (ent_vld[i] && (IDX_W'(i) != head) && (ent_tag[i] == st_tag)) begin
                hit_c     = 1'b1;
                hit_idx_c = IDX_W'(i);
            end
        end
    end

    assign st_ready = (count < CNT_W'(DEPTH)) || hit_c;
    assign accept_c = st_valid && st_ready;
    assign wr_en_c  = accept_c && (|be_c);
    assign alloc_c  = wr_en_c && !hit_c;
    assign drain_c  = dr_valid && dr_ready;
    assign wr_idx_c = hit_c ? hit_idx_c : tail;

    // Byte merge of the store into the target entry's current contents.
    always_comb begin
        wr_line_c = ent_data[wr_idx_c];
        for (int unsigned k = 0; k < LINE_BYTES; k++) begin
            if (be_c[k]) begin
                wr_line_c[k] = lane_data_c[8*k +: 8];
            end
        end
    end

    always_comb begin
        count_nxt_c = count;
        case ({alloc_c, drain_c})
            2'b10:   count_nxt_c = count + CNT_W'(1);
            2'b01:   count_nxt_c = count - CNT_W'(1);
            default: count_nxt_c = count;
        endcase
    end

    // Entry, pointer and pulse state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_vld  <= '0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            misalign <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_tag[i]  <= '0;
                ent_data[i] <= '0;
                ent_mask[i] <= '0;
            end
        end else begin
            misalign <= accept_c && misalign_c;
            count    <= count_nxt_c;
            // Drain and allocate never target the same slot: equal pointers
            // mean either empty (no drain) or full (no allocate).
            if (drain_c) begin
                ent_vld[head] <= 1'b0;
                head          <= head + IDX_W'(1);
            end
            if (wr_en_c) begin
                ent_data[wr_idx_c] <= wr_line_c;
                ent_mask[wr_idx_c] <= hit_c ? (ent_mask[wr_idx_c] | be_c) : be_c;
            end
            if (alloc_c) begin
                ent_vld[tail] <= 1'b1;
                ent_tag[tail] <= st_tag;
                tail          <= tail + IDX_W'(1);
            end
        end
    end

    assign dr_valid = (count != '0);
    assign empty    = (count == '0);
    assign dr_addr  = {ent_tag[head], OFF_W'(0)};
    assign dr_data  = ent_data[head];
    assign dr_mask  = ent_mask[head];

`ifdef SCB_LOAD_FWD_EN
    logic [TAG_W-1:0] ld_tag;
    logic [IDX_W-1:0] fwd_idx_c;

    assign ld_tag = ld_addr[ADDR_W-1:OFF_W];

    // Walk oldest to youngest so younger entries overwrite older lanes.
    always_comb begin
        ld_fwd_data = '0;
        ld_fwd_mask = '0;
        fwd_idx_c   = '0;
        for (int unsigned j = 0; j < DEPTH; j++) begin
            fwd_idx_c = head + IDX_W'(j);
            if (ent_vld[fwd_idx_c] && (ent_tag[fwd_idx_c] == ld_tag)) begin
                for (int unsigned k = 0; k < LINE_BYTES; k++) begin
                    if (ent_mask[fwd_idx_c][k]) begin
                        ld_fwd_data[8*k +: 8] = ent_data[fwd_idx_c][k];
                        ld_fwd_mask[k]        = 1'b1;
                    end
                end
            end
        end
    end
`endif

endmodule
